// File: rtl/unified_memory.sv
// Dual-port (fetch + load/store) byte-addressed word memory with per-byte write enables.
// Optional power-on clear sequence enabled by defining UNIFIED_MEMORY_CLEAR_EN.
module unified_memory #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  output logic                    ready,
  input  logic                    inst_req,
  input  logic [ADDR_WIDTH-1:0]   inst_addr,
  output logic [DATA_WIDTH-1:0]   inst_dout,
  output logic                    inst_valid,
  output logic                    inst_err,
  input  logic                    data_req,
  input  logic                    data_we,
  input  logic [DATA_WIDTH/8-1:0] data_be,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_din,
  output logic [DATA_WIDTH-1:0]   data_dout,
  output logic                    data_valid,
  output logic                    data_err
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int OB = $clog2(NB);
  localparam int IB = $clog2(DEPTH);

  function automatic logic addr_bad(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] hi;
    hi = a >> (OB + IB);
    return (a[OB-1:0] != '0) || (hi != '0);
  endfunction

  logic          ready_reg;
  logic          clear_we;
  logic [IB-1:0] clr_idx;

`ifdef UNIFIED_MEMORY_CLEAR_EN
  localparam logic [0:0]    ST_CLEAR = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [IB-1:0] LAST_IDX = IB'(DEPTH - 1);

  logic [0:0]    state_reg, state_next;
  logic [IB-1:0] clr_cnt_reg, clr_cnt_next;
  logic          ready_next;

  always_comb begin
    state_next   = state_reg;
    clr_cnt_next = clr_cnt_reg;
    ready_next   = ready_reg;
    case (state_reg)
      ST_CLEAR: begin
        clr_cnt_next = clr_cnt_reg + 1'b1;
        if (clr_cnt_reg == LAST_IDX) begin
          state_next = ST_RUN;
          ready_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg   <= ST_CLEAR;
      clr_cnt_reg <= '0;
      ready_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clr_cnt_reg <= clr_cnt_next;
      ready_reg   <= ready_next;
    end
  end

  assign clear_we = (state_reg == ST_CLEAR);
  assign clr_idx  = clr_cnt_reg;
`else
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ready_reg <= 1'b0;
    else        ready_reg <= 1'b1;
  end

  assign clear_we = 1'b0;
  assign clr_idx  = '0;
`endif

  logic          inst_fire, data_fire;
  logic          inst_bad, data_bad;
  logic          inst_rd_en, data_rd_en, data_wr_en;
  logic [IB-1:0] inst_idx, data_idx;

  assign inst_fire  = inst_req & ready_reg;
  assign data_fire  = data_req & ready_reg;
  assign inst_bad   = addr_bad(inst_addr);
  assign data_bad   = addr_bad(data_addr);
  assign inst_idx   = inst_addr[OB+IB-1:OB];
  assign data_idx   = data_addr[OB+IB-1:OB];
  assign inst_rd_en = inst_fire & ~inst_bad;
  assign data_rd_en = data_fire & ~data_we & ~data_bad;
  assign data_wr_en = data_fire & data_we & ~data_bad;

  logic [DATA_WIDTH-1:0] inst_word, data_word;

  // One 8-bit RAM per byte lane; read registers load only on a good read so they hold between accesses.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] inst_q;
      logic [7:0] data_q;

      always_ff @(posedge clock) begin
        if (clear_we)
          mem[clr_idx] <= 8'h00;
        else if (data_wr_en && data_be[gi])
          mem[data_idx] <= data_din[8*gi +: 8];
        if (inst_rd_en)
          inst_q <= mem[inst_idx];
        if (data_rd_en)
          data_q <= mem[data_idx];
      end

      assign inst_word[8*gi +: 8] = inst_q;
      assign data_word[8*gi +: 8] = data_q;
    end
  endgenerate

  // zero flags force all-zero output after reset and after an erroring read
  logic inst_valid_reg, inst_err_reg, inst_zero_reg;
  logic data_valid_reg, data_err_reg, data_zero_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inst_valid_reg <= 1'b0;
      inst_err_reg   <= 1'b0;
      inst_zero_reg  <= 1'b1;
      data_valid_reg <= 1'b0;
      data_err_reg   <= 1'b0;
      data_zero_reg  <= 1'b1;
    end else begin
      inst_valid_reg <= inst_fire;
      data_valid_reg <= data_fire;
      if (inst_fire) begin
        inst_err_reg  <= inst_bad;
        inst_zero_reg <= inst_bad;
      end
      if (data_fire)
        data_err_reg <= data_bad;
      if (data_fire && !data_we)
        data_zero_reg <= data_bad;
    end
  end

  assign ready      = ready_reg;
  assign inst_valid = inst_valid_reg;
  assign inst_err   = inst_err_reg;
  assign inst_dout  = inst_zero_reg ? '0 : inst_word;
  assign data_valid = data_valid_reg;
  assign data_err   = data_err_reg;
  assign data_dout  = data_zero_reg ? '0 : data_word;

endmodule

// File: tb/tb_unified_memory.sv
// Scoreboard bench for unified_memory: stimulus pushes expectations from a word-array model,
// a negedge monitor pops and compares on every valid pulse.
module tb_unified_memory;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;
  localparam int AW    = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          ready;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [DW-1:0] inst_dout;
  logic          inst_valid, inst_err;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [3:0]    data_be = '0;
  logic [AW-1:0] data_addr = '0;
  logic [DW-1:0] data_din = '0;
  logic [DW-1:0] data_dout;
  logic          data_valid, data_err;

  unified_memory #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset(reset), .ready(ready),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_dout(inst_dout),
    .inst_valid(inst_valid), .inst_err(inst_err),
    .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
    .data_din(data_din), .data_dout(data_dout), .data_valid(data_valid), .data_err(data_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct {
    logic [31:0] dout;
    logic        err;
    int          cyc;
    logic [31:0] addr;
  } exp_t;

  exp_t        iq[$];
  exp_t        dq[$];
  exp_t        mi, md;
  logic [31:0] mm [DEPTH];
  logic [31:0] last_dd = '0;
  logic [31:0] seen_i = '0, seen_d = '0;
  logic        seen_ie = 1'b0, seen_de = 1'b0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          accept = 0;

  task automatic check(input string name, input bit ok, input string det);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: %s", name, det);
    end
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a % 4 != 0) || (a / 4 >= DEPTH);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  // Drive one cycle of requests; expectations use the model state before this cycle's write.
  task automatic step(input bit ir, input logic [31:0] ia, input bit dr, input bit dw,
                      input logic [3:0] be, input logic [31:0] da, input logic [31:0] dd);
    exp_t e;
    inst_req = ir; inst_addr = ia;
    data_req = dr; data_we = dw; data_be = be; data_addr = da; data_din = dd;
    if (accept && ir) begin
      e.addr = ia; e.err = bad(ia); e.cyc = cyc + 1;
      e.dout = e.err ? 32'h0 : mm[widx(ia)];
      iq.push_back(e);
    end
    if (accept && dr) begin
      e.addr = da; e.err = bad(da); e.cyc = cyc + 1;
      if (dw) begin
        e.dout = last_dd;
        if (!e.err)
          for (int b = 0; b < 4; b++)
            if (be[b]) mm[widx(da)][8*b +: 8] = dd[8*b +: 8];
      end else begin
        e.dout = e.err ? 32'h0 : mm[widx(da)];
        last_dd = e.dout;
      end
      dq.push_back(e);
    end
    @(posedge clock); #1;
  endtask

  task automatic idle();
    step(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
  endtask

  function automatic logic [31:0] rand_addr();
    int r;
    r = $urandom_range(0, 19);
    if (r == 0) return ({$urandom} & 32'h0000_0FFC) | 32'($urandom_range(1, 3));
    if (r == 1) return 32'h0000_1000 + (32'($urandom_range(0, 1023)) << 2);
    if (r == 2) return {$urandom} & 32'hFFFF_FFFC;
    if (r < 10) return 32'($urandom_range(0, 15)) << 2;
    return 32'($urandom_range(0, DEPTH - 1)) << 2;
  endfunction

  task automatic rand_step();
    logic [31:0] ia, da;
    ia = rand_addr();
    da = ($urandom_range(0, 9) == 0) ? ia : rand_addr();
    step(bit'($urandom_range(0, 1)), ia, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
         4'($urandom_range(0, 15)), da, $urandom);
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      seen_i = '0; seen_ie = 1'b0; seen_d = '0; seen_de = 1'b0;
    end else begin
      if (inst_valid) begin
        if (iq.size() == 0) begin
          check("inst_unexpected", 0, $sformatf("valid at cyc %0d with no request, dout=%h", cyc, inst_dout));
        end else begin
          mi = iq.pop_front();
          $display("inst cyc=%0d addr=%h dout=%h err=%b", cyc, mi.addr, inst_dout, inst_err);
          check("inst", inst_dout === mi.dout && inst_err === mi.err && cyc == mi.cyc,
                $sformatf("addr=%h got dout=%h err=%b cyc=%0d, want dout=%h err=%b cyc=%0d",
                          mi.addr, inst_dout, inst_err, cyc, mi.dout, mi.err, mi.cyc));
          seen_i = mi.dout; seen_ie = mi.err;
        end
      end else begin
        check("inst_hold", inst_dout === seen_i && inst_err === seen_ie,
              $sformatf("idle got dout=%h err=%b, want dout=%h err=%b", inst_dout, inst_err, seen_i, seen_ie));
      end
      if (data_valid) begin
        if (dq.size() == 0) begin
          check("data_unexpected", 0, $sformatf("valid at cyc %0d with no request, dout=%h", cyc, data_dout));
        end else begin
          md = dq.pop_front();
          $display("data cyc=%0d addr=%h dout=%h err=%b", cyc, md.addr, data_dout, data_err);
          check("data", data_dout === md.dout && data_err === md.err && cyc == md.cyc,
                $sformatf("addr=%h got dout=%h err=%b cyc=%0d, want dout=%h err=%b cyc=%0d",
                          md.addr, data_dout, data_err, cyc, md.dout, md.err, md.cyc));
          seen_d = md.dout; seen_de = md.err;
        end
      end else begin
        check("data_hold", data_dout === seen_d && data_err === seen_de,
              $sformatf("idle got dout=%h err=%b, want dout=%h err=%b", data_dout, data_err, seen_d, seen_de));
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, ready === 1'b0, $sformatf("got %b want 0", ready));
    check({tag, "_inst_dout"}, inst_dout === 32'h0, $sformatf("got %h want 0", inst_dout));
    check({tag, "_data_dout"}, data_dout === 32'h0, $sformatf("got %h want 0", data_dout));
    check({tag, "_valids"}, {inst_valid, data_valid} === 2'b00, $sformatf("got %b want 00", {inst_valid, data_valid}));
    check({tag, "_errs"}, {inst_err, data_err} === 2'b00, $sformatf("got %b want 00", {inst_err, data_err}));
  endtask

  // Counts edges after reset release until ready rises, issuing ignored random requests meanwhile.
  task automatic wait_ready(input int want);
    int n;
    n = 0;
    while (ready !== 1'b1 && n < 1200) begin
      rand_step();
      n++;
    end
    check("ready_edges", n == want, $sformatf("ready after %0d edges, want %0d", n, want));
    idle();
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_reset_outputs("reset");
    reset = 1'b1;
    check("ready_pre_edge", ready === 1'b0, $sformatf("got %b want 0", ready));
`ifdef UNIFIED_MEMORY_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) mm[i] = 32'h0;
    repeat (500) rand_step();
    reset = 1'b0;
    #1;
    check_reset_outputs("midclear");
    @(posedge clock); #1;
    reset = 1'b1;
    wait_ready(DEPTH);
    accept = 1;
    step(0, 32'h0, 1, 0, 4'h0, 32'h000, 32'h0);
    step(1, 32'hFFC, 1, 0, 4'h0, 32'hFFC, 32'h0);
`else
    wait_ready(1);
    accept = 1;
    for (int i = 0; i < DEPTH; i++) step(0, 32'h0, 1, 1, 4'hF, 32'(i * 4), $urandom);
    step(0, 32'h0, 1, 1, 4'hF, 32'h004, 32'h0000_0005);
    step(1, 32'h004, 0, 0, 4'h0, 32'h0, 32'h0);
`endif
    step(0, 32'h0, 1, 1, 4'hF, 32'h010, 32'hDEAD_BEEF);
    step(0, 32'h0, 1, 1, 4'h1, 32'h010, 32'h0000_00AA);
    step(0, 32'h0, 1, 0, 4'h0, 32'h010, 32'h0);
    idle();
    step(0, 32'h0, 1, 1, 4'h0, 32'h010, 32'h5555_5555);
    step(0, 32'h0, 1, 1, 4'hF, 32'h020, 32'h1111_1111);
    step(1, 32'h020, 1, 1, 4'hF, 32'h020, 32'h2222_2222);
    step(1, 32'h020, 0, 0, 4'h0, 32'h0, 32'h0);
    step(0, 32'h0, 1, 0, 4'h0, 32'h013, 32'h0);
    step(1, 32'h002, 1, 1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
    step(1, 32'h000, 1, 0, 4'h0, 32'h000, 32'h0);
    idle();
    repeat (800) rand_step();
    repeat (3) idle();
    check("drain_inst", iq.size() == 0, $sformatf("%0d pending, want 0", iq.size()));
    check("drain_data", dq.size() == 0, $sformatf("%0d pending, want 0", dq.size()));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
